// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings and instruction-class helpers for the CPU sequencer.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [3:0] OPC_JMP    = 4'b0011;
  localparam logic [3:0] OPC_ST     = 4'b1100;
  localparam logic [3:0] OPC_NOWB_A = 4'b1000;
  localparam logic [3:0] OPC_NOWB_B = 4'b0100;

  // Opcodes whose result lands in the register file (need a WB cycle).
  function automatic logic is_reg_write(input logic [3:0] opc);
    return (opc[3:2] != 2'b00) && (opc != OPC_NOWB_A) &&
           (opc != OPC_NOWB_B) && (opc != OPC_ST);
  endfunction

  // Flags are left alone by control-flow and store instructions.
  function automatic logic updates_flags(input logic [3:0] opc);
    return (opc != OPC_JMP) && (opc != OPC_ST);
  endfunction

endpackage

// File: rtl/cpu_sequencer_ack_timer.sv
// Handshake wait counter shared by the fetch and store handshakes.
// expired flags the last permitted wait cycle: if the ack is still missing
// in that cycle, the counter has seen LIMIT non-ack cycles and the owner faults.
module cpu_sequencer_ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT - 1));

  // Count non-ack cycles; cleared on reset and on every state entry.
  always_ff @(posedge clk) begin
    if (rst || clr)            cnt <= '0;
    else if (inc && !expired)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC, IR and flags and steps each
// instruction through FETCH/DECODE/EXEC/(MEM|WB) with memory handshakes.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int OPR_W       = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [3+OPR_W:0]  imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        ir_opcode,
  output logic [OPR_W-1:0]  ir_operand,
  input  logic              alu_zf,
  input  logic              alu_sf,
  input  logic              alu_cf,
  output logic              zf,
  output logic              sf,
  output logic              cf,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              reg_we,
  output logic              busy,
  output logic              fault
);

  state_t state, nxt, boundary;
  logic   tmr_clr, tmr_inc, tmr_exp;
  logic   jmp_taken;

  cpu_sequencer_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_exp)
  );

  // Jump decision uses flags left by an earlier instruction.
  assign jmp_taken = (ir_opcode == OPC_JMP) && !zf && !sf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state and strobes; strobes are pure state decodes so they never overlap.
  always_comb begin
    nxt      = state;
    tmr_inc  = 1'b0;
    imem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b1;
    fault    = 1'b0;
    boundary = (halt_req || !run) ? S_IDLE : S_FETCH;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        tmr_inc  = !imem_ack;
        if (imem_ack)     nxt = S_DECODE;
        else if (tmr_exp) nxt = S_FAULT;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (ir_opcode == OPC_ST)        nxt = S_MEM;
        else if (is_reg_write(ir_opcode)) nxt = S_WB;
        else                            nxt = boundary;
      end
      S_MEM: begin
        dmem_we = 1'b1;
        tmr_inc = !dmem_ack;
        if (dmem_ack)     nxt = boundary;
        else if (tmr_exp) nxt = S_FAULT;
      end
      S_WB: begin
        reg_we = 1'b1;
        nxt    = boundary;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
    tmr_clr = (nxt != state);
  end

  // Architectural registers: IR loads on fetch ack, PC/flags update in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir_opcode  <= '0;
      ir_operand <= '0;
      zf         <= 1'b0;
      sf         <= 1'b0;
      cf         <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir_opcode  <= imem_rdata[3+OPR_W:OPR_W];
            ir_operand <= imem_rdata[OPR_W-1:0];
          end
        end
        S_EXEC: begin
          if (updates_flags(ir_opcode)) begin
            zf <= alu_zf;
            sf <= alu_sf;
            cf <= alu_cf;
          end
          pc <= jmp_taken ? ADDR_W'(ir_operand) : pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: hand-sequenced instruction stream with
// cycle-exact expectations.
module tb_cpu_sequencer;

  localparam int ADDR_W = 5;
  localparam int OPR_W  = 5;

  logic              clk = 1'b0;
  logic              rst, run, halt_req;
  logic              imem_req, imem_ack;
  logic [3+OPR_W:0]  imem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        ir_opcode;
  logic [OPR_W-1:0]  ir_operand;
  logic              alu_zf, alu_sf, alu_cf;
  logic              zf, sf, cf;
  logic              dmem_we, dmem_ack, reg_we, busy, fault;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt, bad_cnt;

  cpu_sequencer #(.ADDR_W(ADDR_W), .OPR_W(OPR_W), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .ir_opcode(ir_opcode), .ir_operand(ir_operand),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf),
    .zf(zf), .sf(sf), .cf(cf),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic z, input logic s, input logic c);
    alu_zf = z; alu_sf = s; alu_cf = c;
  endtask

  // Present one instruction word for a single zero-wait fetch cycle.
  task automatic fetch(input logic [3:0] opc, input logic [4:0] opr);
    imem_ack   = 1'b1;
    imem_rdata = {opc, opr};
    tick();
    imem_ack   = 1'b0;
  endtask

  initial begin
    rst = 1; run = 0; halt_req = 0; imem_ack = 0; imem_rdata = '0;
    dmem_ack = 0; set_alu(0, 0, 0);
    tick(); tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", 32'({ir_opcode, ir_operand}), 0);
    chk("rst_flags", 32'({zf, sf, cf}), 0);
    chk("rst_strobes", 32'({imem_req, dmem_we, reg_we}), 0);
    chk("rst_busy_fault", 32'({busy, fault}), 0);

    // ALU write op 1001: FETCH c1, DECODE, EXEC, WB c4
    rst = 0; run = 1;
    tick();
    chk("start_imem_req", 32'(imem_req), 1);
    chk("start_busy", 32'(busy), 1);
    set_alu(0, 0, 1);
    fetch(4'b1001, 5'd0);
    chk("dec_opcode", 32'(ir_opcode), 4'h9);
    chk("dec_no_req", 32'(imem_req), 0);
    tick();
    chk("exec_no_we", 32'(reg_we), 0);
    chk("exec_pc", 32'(pc), 0);
    tick();
    chk("wb_reg_we", 32'(reg_we), 1);
    chk("wb_pc", 32'(pc), 1);
    chk("wb_flags", 32'({zf, sf, cf}), 3'b001);
    tick();
    chk("fetch2_we_off", 32'(reg_we), 0);
    chk("fetch2_req", 32'(imem_req), 1);

    // Taken jump to 20; ALU flags ignored
    set_alu(1, 1, 0);
    fetch(4'b0011, 5'd20);
    tick();
    chk("jmp_exec_no_we", 32'(reg_we), 0);
    tick();
    chk("jmp_pc", 32'(pc), 20);
    chk("jmp_flags", 32'({zf, sf, cf}), 3'b001);
    chk("jmp_refetch", 32'(imem_req), 1);

    // Writing op 0101 sets zf
    set_alu(1, 0, 0);
    fetch(4'b0101, 5'd7);
    tick(); tick();
    chk("alu2_wb", 32'(reg_we), 1);
    chk("alu2_pc", 32'(pc), 21);
    chk("alu2_zf", 32'({zf, sf, cf}), 3'b100);
    tick();

    // Jump not taken with zf=1
    set_alu(0, 0, 0);
    fetch(4'b0011, 5'd5);
    tick(); tick();
    chk("jmpnt_pc", 32'(pc), 22);
    chk("jmpnt_zf", 32'(zf), 1);

    // Store with dmem_ack on 4th MEM cycle
    set_alu(0, 1, 1);
    fetch(4'b1100, 5'd3);
    tick(); tick();
    we_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (dmem_we) we_cnt++;
      if (reg_we || imem_req) bad_cnt++;
      if (i == 3) dmem_ack = 1;
      tick();
    end
    dmem_ack = 0;
    chk("st_we_cycles", 32'(we_cnt), 4);
    chk("st_excl", 32'(bad_cnt), 0);
    chk("st_back_fetch", 32'({imem_req, dmem_we}), 2'b10);
    chk("st_pc", 32'(pc), 23);
    chk("st_flags", 32'({zf, sf, cf}), 3'b100);

    // Non-writing 1000 updates flags, no WB
    set_alu(0, 0, 0);
    fetch(4'b1000, 5'd0);
    tick(); tick();
    chk("nowb_pc", 32'(pc), 24);
    chk("nowb_flags", 32'({zf, sf, cf}), 0);
    chk("nowb_refetch", 32'(imem_req), 1);

    fetch(4'b0011, 5'd31);
    tick(); tick();
    chk("jmp31_pc", 32'(pc), 31);

    // Opcode 0000 at pc 31 wraps; halt raised in DECODE
    set_alu(0, 1, 1);
    fetch(4'b0000, 5'd9);
    halt_req = 1;
    tick();
    chk("halt_exec_busy", 32'(busy), 1);
    tick();
    chk("halt_idle", 32'({busy, imem_req}), 0);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_flags", 32'({zf, sf, cf}), 3'b011);
    halt_req = 0;
    tick();

    // Store, reset during MEM
    fetch(4'b1100, 5'd1);
    tick(); tick();
    chk("mem_we", 32'(dmem_we), 1);
    chk("mem_pc", 32'(pc), 1);
    rst = 1;
    tick();
    chk("mrst_we", 32'(dmem_we), 0);
    chk("mrst_pc", 32'(pc), 0);
    chk("mrst_flags", 32'({zf, sf, cf}), 0);
    chk("mrst_ir", 32'({ir_opcode, ir_operand}), 0);
    chk("mrst_busy", 32'(busy), 0);

    // Ack arrives on the last allowed wait cycle: ack wins
    rst = 0;
    tick();
    chk("lim_req_c1", 32'(imem_req), 1);
    for (int i = 0; i < 14; i++) tick();
    chk("lim_req_c15", 32'({imem_req, fault}), 2'b10);
    fetch(4'b0100, 5'd2);
    chk("lim_ack_wins", 32'({fault, ir_opcode}), 5'h04);
    run = 0;
    tick(); tick();
    chk("lim_idle", 32'({busy, pc}), 1);

    // Timeout: 15 non-ack fetch cycles -> FAULT
    run = 1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("to_c15_req", 32'(imem_req), 1);
    tick();
    chk("to_fault", 32'({fault, busy, imem_req}), 3'b100);
    imem_ack = 1; imem_rdata = {4'b1001, 5'd0};
    tick(); tick();
    imem_ack = 0;
    chk("to_frozen", 32'({fault, ir_opcode, pc}), {1'b1, 4'h4, 5'd1});
    rst = 1;
    tick();
    chk("to_rst", 32'({fault, pc}), 0);
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
